// File: rtl/input_ctrl.sv
// Input-side frame controller: slices a DMA sample stream into FRAME_LEN-sample frames for the FFT core,
// issuing one config word ahead of each frame. Optional short-packet zero padding via INPUT_CTRL_ZERO_PAD_EN.
module input_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 8,
    parameter int SCALE_W   = 8,
    parameter int CFG_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_data,
    input  logic               i_data_valid,
    input  logic               i_data_last,
    output logic               o_data_ready,
    output logic [31:0]        o_data,
    output logic               o_data_valid,
    output logic               o_data_last,
    input  logic               i_data_ready,
    output logic [CFG_W-1:0]   o_cfg_data,
    output logic               o_cfg_valid,
    input  logic               i_cfg_ready,
    input  logic               i_fwd_inv,
    input  logic [SCALE_W-1:0] i_scale_sch,
    output logic [15:0]        o_frame_cnt,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_CFG    = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic [CFG_W-1:0]   cfg_data_q, cfg_data_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               data_ready;
    logic               out_fire;

    assign out_fire = valid_q & i_data_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        cfg_valid_d = cfg_valid_q;
        cfg_data_d  = cfg_data_q;
        frame_cnt_d = frame_cnt_q;
        data_ready  = 1'b0;

        // Draining the output register; a same-cycle reload below keeps valid high.
        if (out_fire) begin
            valid_d = 1'b0;
            if (last_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_CFG: begin
                if (!cfg_valid_q) begin
                    cfg_valid_d            = 1'b1;
                    cfg_data_d             = '0;
                    cfg_data_d[SCALE_W:0]  = {i_scale_sch, i_fwd_inv};
                end else if (i_cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                data_ready = !valid_q || i_data_ready;
                if (i_data_valid && data_ready) begin
                    data_d  = i_data;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == CNT_LAST);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CFG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`ifdef INPUT_CTRL_ZERO_PAD_EN
                        if (i_data_last) begin
                            state_d = ST_PAD;
                        end
`endif
                    end
                end
            end
            ST_PAD: begin
                // Fill the rest of a short frame with zero samples at the sink's pace.
                if (!valid_q || i_data_ready) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == CNT_LAST);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CFG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CFG;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_CFG;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_data_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_data_q  <= cfg_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_data_ready = data_ready;
    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_data_last  = last_q;
    assign o_cfg_data   = cfg_data_q;
    assign o_cfg_valid  = cfg_valid_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_busy       = (state_q != ST_CFG) || valid_q;

endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl: accepted samples are queued as expectations and popped on each
// FFT-side handshake; zero-pad expectations follow the INPUT_CTRL_ZERO_PAD_EN build.
module tb_input_ctrl;

    localparam int FL = 256;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        i_data_last;
    logic        o_data_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        o_data_last;
    logic        i_data_ready;
    logic [15:0] o_cfg_data;
    logic        o_cfg_valid;
    logic        i_cfg_ready;
    logic        i_fwd_inv;
    logic [7:0]  i_scale_sch;
    logic [15:0] o_frame_cnt;
    logic        o_busy;

    input_ctrl #(.FRAME_LEN(FL), .CNT_W(8), .SCALE_W(8), .CFG_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_data_last  (i_data_last),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_cfg_data   (o_cfg_data),
        .o_cfg_valid  (o_cfg_valid),
        .i_cfg_ready  (i_cfg_ready),
        .i_fwd_inv    (i_fwd_inv),
        .i_scale_sch  (i_scale_sch),
        .o_frame_cnt  (o_frame_cnt),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          pos = 0;
    bit          cfg_open = 0;
    int          pad_left = 0;
    int          exp_frames = 0;
    int          cfg_fires = 0;
    bit          stall_pend = 0;
    logic [31:0] stall_data;
    logic        stall_last;
    logic [31:0] next_val = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check/score at the falling edge, return just after the rising edge.
    task automatic step(output bit in_f);
        bit   out_f, cfg_f, exp_rdy;
        exp_t e;
        @(negedge clk);
        in_f  = i_data_valid & o_data_ready;
        out_f = o_data_valid & i_data_ready;
        cfg_f = o_cfg_valid & i_cfg_ready;
        if (i_rst_n) begin
            check_val("frame_cnt", o_frame_cnt, exp_frames[15:0]);
            exp_rdy = cfg_open && (pad_left == 0) && ((sbq.size() == 0) || i_data_ready);
            check_val("data_ready", o_data_ready, exp_rdy);
            if (stall_pend) begin
                check_val("stall_valid", o_data_valid, 1);
                check_val("stall_data", o_data, stall_data);
                check_val("stall_last", o_data_last, stall_last);
            end
            stall_pend = o_data_valid & !i_data_ready;
            stall_data = o_data;
            stall_last = o_data_last;
            if (out_f) begin
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check_val("out_data", o_data, e.d);
                    check_val("out_last", o_data_last, e.l);
                    if (e.l) exp_frames++;
                end else if (pad_left > 0) begin
                    check_val("pad_data", o_data, 0);
                    check_val("pad_last", o_data_last, pad_left == 1);
                    if (pad_left == 1) exp_frames++;
                    pad_left--;
                end else begin
                    check_val("out_unexpected", o_data_valid, 0);
                end
            end
            if (cfg_f) begin
                check_val("cfg_data", o_cfg_data, {7'd0, i_scale_sch, i_fwd_inv});
                check_val("cfg_dup", cfg_open, 0);
                cfg_open = 1;
                cfg_fires++;
            end
            if (in_f) begin
                e.d = i_data;
                e.l = (pos == FL - 1);
                sbq.push_back(e);
                if (pos == FL - 1) begin
                    pos = 0;
                    cfg_open = 0;
                end else begin
`ifdef INPUT_CTRL_ZERO_PAD_EN
                    if (i_data_last) begin
                        pad_left = FL - 1 - pos;
                        pos = 0;
                        cfg_open = 0;
                    end else begin
                        pos++;
                    end
`else
                    pos++;
`endif
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit rand_rdy, input int last_idx, output int cyc);
        int sent = 0;
        bit f;
        cyc = 0;
        i_data_valid = 1;
        i_data       = next_val;
        i_data_last  = (last_idx == 0);
        while (sent < n && cyc < 5000) begin
            i_data_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            step(f);
            cyc++;
            if (f) begin
                sent++;
                next_val++;
                i_data      = next_val;
                i_data_last = (sent == last_idx);
            end
        end
        i_data_valid = 0;
        i_data_last  = 0;
        i_data_ready = 1;
        if (sent < n) check_val("send_timeout", sent, n);
    endtask

    task automatic idle(input int n);
        bit f;
        i_data_valid = 0;
        i_data_ready = 1;
        repeat (n) step(f);
    endtask

    initial begin
        int  cyc;
        int  acc;
        bit  f;
        i_rst_n      = 0;
        i_data       = 0;
        i_data_valid = 0;
        i_data_last  = 0;
        i_data_ready = 1;
        i_cfg_ready  = 1;
        i_fwd_inv    = 1;
        i_scale_sch  = 8'hAA;

        // Test 1: reset state, then a single config pulse
        #12;
        check_val("rst_valid", o_data_valid, 0);
        check_val("rst_cfg_valid", o_cfg_valid, 0);
        check_val("rst_ready", o_data_ready, 0);
        check_val("rst_frame_cnt", o_frame_cnt, 0);
        @(posedge clk); #3;
        i_rst_n = 1;
        @(posedge clk); #1;
        check_val("t1_cfg_latched", o_cfg_valid, 1);
        check_val("t1_cfg_word", o_cfg_data, 16'h0155);
        idle(5);
        check_val("t1_cfg_pulses", cfg_fires, 1);
        check_val("t1_cfg_low", o_cfg_valid, 0);
        check_val("t1_busy", o_busy, 1);

        // Test 2: 512 back-to-back samples, only the config gap between frames
        send(512, 0, -1, cyc);
        check_val("t2_cycles", cyc, 514);
        idle(5);
        check_val("t2_frames", o_frame_cnt, 2);
        check_val("t2_cfgs", cfg_fires, 3);

        // Test 3: random sink backpressure over one frame
        send(256, 1, -1, cyc);
        i_cfg_ready = 0;
        idle(4);
        check_val("t3_frames", o_frame_cnt, 3);

        // Test 4: config stalled for 20 cycles, no sample may enter
        i_data_valid = 1;
        i_data       = next_val;
        acc = 0;
        repeat (20) begin
            step(f);
            if (f) acc++;
        end
        check_val("t4_accepted", acc, 0);
        check_val("t4_cfg_waiting", o_cfg_valid, 1);
        i_cfg_ready = 1;
        send(256, 0, -1, cyc);
        idle(5);
        check_val("t4_frames", o_frame_cnt, 4);

        // Test 5: short packet marked last on sample 99
        send(100, 0, 99, cyc);
        idle(200);
`ifdef INPUT_CTRL_ZERO_PAD_EN
        check_val("t5_frames_pad", o_frame_cnt, 5);
`else
        check_val("t5_frames_nopad", o_frame_cnt, 4);
        send(156, 0, -1, cyc);
        idle(5);
        check_val("t5_frames_done", o_frame_cnt, 5);
`endif

        // Test 6: asynchronous reset in the middle of a frame
        send(37, 0, -1, cyc);
        #2;
        i_rst_n = 0;
        #1;
        check_val("t6_rst_valid", o_data_valid, 0);
        check_val("t6_rst_data", o_data, 0);
        check_val("t6_rst_last", o_data_last, 0);
        check_val("t6_rst_cfg_valid", o_cfg_valid, 0);
        check_val("t6_rst_cfg_data", o_cfg_data, 0);
        check_val("t6_rst_frame_cnt", o_frame_cnt, 0);
        check_val("t6_rst_ready", o_data_ready, 0);
        sbq.delete();
        pos        = 0;
        cfg_open   = 0;
        pad_left   = 0;
        exp_frames = 0;
        stall_pend = 0;
        idle(2);
        #2;
        i_rst_n = 1;
        send(256, 0, -1, cyc);
        idle(5);
        check_val("t6_frames", o_frame_cnt, 1);
        check_val("t6_queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
